// File: rtl/axi4l2core.sv
// AXI4-Lite subordinate replaying one transaction at a time on a req/gnt/rvalid port.
// AXI4L2CORE_RR_EN selects round-robin read/write arbitration (default: writes win).
module axi4l2core #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [ADDR_WIDTH-1:0] AMASK = ~(ADDR_WIDTH'(3));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  prio;
  logic                  idle, grant_rd;
  logic                  ar_hs, aw_hs, w_hs, resp_hs;
  logic                  unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Readys are masked by rst_n so they read 0 throughout reset.
  assign idle     = (state_q == IDLE) && rst_n;
  assign grant_rd = arvalid && !aw_held_q && !w_held_q &&
                    (!(awvalid || wvalid) || prio);
  assign arready  = idle && grant_rd;
  assign awready  = idle && !aw_held_q && !grant_rd;
  assign wready   = idle && !w_held_q && !grant_rd;
  assign ar_hs    = arvalid && arready;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign resp_hs  = we_q ? bready : rready;

  assign mem_req   = (state_q == REQ);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign bvalid    = (state_q == RESP) && we_q;
  assign rvalid    = (state_q == RESP) && !we_q;
  assign bresp     = (bvalid && err_q) ? 2'b10 : 2'b00;
  assign rresp     = (rvalid && err_q) ? 2'b10 : 2'b00;
  assign rdata     = rdata_q;

`ifdef AXI4L2CORE_RR_EN
  logic prio_q, prio_d;
  assign prio = prio_q;

  always_comb begin
    prio_d = prio_q;
    if (state_q == RESP && resp_hs) prio_d = we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  assign prio = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d  = araddr & AMASK;
          be_d    = 4'hF;
          we_d    = 1'b0;
          state_d = REQ;
        end else begin
          if (aw_hs) begin
            addr_d    = awaddr & AMASK;
            aw_held_d = 1'b1;
          end
          if (w_hs) begin
            wdata_d  = wdata;
            be_d     = wstrb;
            w_held_d = 1'b1;
          end
          if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
            we_d    = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: if (mem_gnt) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = we_q ? 32'h0 : mem_rdata;
          err_d   = mem_err;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4l2core.sv
// Directed bench for axi4l2core: read/write paths, errors, back-pressure,
// arbitration and reset during a grant stall.
module tb_axi4l2core;

  logic        clk, rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb, mem_be;
  logic [1:0]  bresp, rresp;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;

  int checks = 0;
  int errors = 0;

  axi4l2core #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // One full memory-side transaction with all AXI valids left as they are.
  task automatic serve(input string tag, output logic we);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, mem_req, 1);
    we = mem_we;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
  endtask

  logic       we_seen;
  logic [3:0] exp_we;

  initial begin
    rst_n = 1'b0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    {awaddr, araddr, wdata, mem_rdata} = '0;
    {awprot, arprot, wstrb} = '0;
    {mem_gnt, mem_rvalid, mem_err} = '0;
`ifdef AXI4L2CORE_RR_EN
    exp_we = 4'b0101;
`else
    exp_we = 4'b1111;
`endif

    // Reset state, with valids asserted so readys are exercised
    repeat (3) tick();
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    all_zero("reset");
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single read to 0x1006
    arvalid = 1'b1; araddr = 32'h0000_1006;
    #1;
    chk("rd_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    #1;
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h0000_1004);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_be", mem_be, 4'hF);
    chk("rd_arready_busy", arready, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_req_dropped", mem_req, 0);
    chk("rd_rvalid_early", rvalid, 0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_rresp", rresp, 2'b00);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    #1;
    chk("rd_rvalid_done", rvalid, 0);

    // W two cycles ahead of AW
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'b0011;
    #1;
    chk("wr_wready", wready, 1);
    tick();
    wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h0000_0500;
    #1;
    chk("wr_wready_held", wready, 0);
    chk("wr_ar_blocked", arready, 0);
    chk("wr_no_req", mem_req, 0);
    tick();
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0000_0020;
    #1;
    chk("wr_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    #1;
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_be", mem_be, 4'b0011);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("wr_bvalid", bvalid, 1);
    chk("wr_bresp", bresp, 2'b00);
    chk("wr_no_rvalid", rvalid, 0);
    chk("wr_rdata_zero", rdata, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1;
    chk("wr_bvalid_done", bvalid, 0);

    // Read with memory error
    arvalid = 1'b1; araddr = 32'h0000_0044;
    tick();
    arvalid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk("err_rvalid", rvalid, 1);
    chk("err_rresp", rresp, 2'b10);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // R back-pressure for five cycles with a new AR pending
    arvalid = 1'b1; araddr = 32'h0000_0100;
    tick();
    arvalid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    arvalid = 1'b1; araddr = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rdata", rdata, 32'h55AA_55AA);
      chk("bp_rresp", rresp, 2'b00);
      chk("bp_arready", arready, 0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    #1;
    chk("bp_rvalid_done", rvalid, 0);
    chk("bp_arready_after", arready, 1);
    arvalid = 1'b0;
    tick();

    // Continuous contention
    arvalid = 1'b1; araddr = 32'h0000_0090;
    awvalid = 1'b1; awaddr = 32'h0000_0080;
    wvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve("cont", we_seen);
      chk($sformatf("cont_we%0d", i), we_seen, exp_we[i]);
    end
    {arvalid, awvalid, wvalid, bready, rready} = '0;
    tick();
    tick();

    // Grant stall, then reset mid-transaction
    arvalid = 1'b1; araddr = 32'h0000_0300;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h300);
      tick();
    end
    rst_n = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    all_zero("midrst");
    {arvalid, awvalid, wvalid} = '0;
    tick();
    rst_n = 1'b1;
    rready = 1'b1; bready = 1'b1;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rvalid", rvalid, 0);
      chk("post_bvalid", bvalid, 0);
      chk("post_req", mem_req, 0);
      tick();
    end
    {mem_gnt, mem_rvalid, rready, bready} = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
